// File: rtl/sand_level_ctrl_pkg.sv
// rtl/sand_level_ctrl_pkg.sv - shared types and constants for the hourglass sand level controller
package sand_level_ctrl_pkg;

    localparam int ROW_W                   = 11;
    localparam int SAND_DEPTH_DEFAULT      = 68;
    localparam int FRAMES_PER_STEP_DEFAULT = 30;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } sand_state_e;

endpackage

// File: rtl/sand_level_ctrl_frame_divider.sv
// rtl/sand_level_ctrl_frame_divider.sv - frame tick divider producing one step pulse per FRAMES_PER_STEP ticks
module frame_divider #(
    parameter int FRAMES_PER_STEP = 30
) (
    input  logic clk,
    input  logic resetn_i,
    input  logic clear_i,
    input  logic tick_i,
    output logic step_o
);

    localparam logic [7:0] LAST = 8'(FRAMES_PER_STEP - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // step_o is combinational so the level update lands on the same edge as the wrapping tick
    always_comb begin
        count_d = count_q;
        step_o  = 1'b0;
        if (clear_i) begin
            count_d = 8'd0;
        end else if (tick_i) begin
            if (count_q == LAST) begin
                count_d = 8'd0;
                step_o  = 1'b1;
            end else begin
                count_d = count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn_i) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sand_level_ctrl.sv
// rtl/sand_level_ctrl.sv - hourglass sand level state machine with registered surface rows
module sand_level_ctrl
    import sand_level_ctrl_pkg::*;
#(
    parameter int FRAMES_PER_STEP = FRAMES_PER_STEP_DEFAULT,
    parameter int SAND_DEPTH      = SAND_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             BTN_S,
    input  logic [ROW_W-1:0] ori_row,
    input  logic             frame_tick,
    input  logic             start,
    input  logic             pause,
    output logic [ROW_W-1:0] lower_row,
    output logic [ROW_W-1:0] upper_row,
    output logic             running,
    output logic             done
);

    localparam logic [6:0]       DEPTH_L = 7'(SAND_DEPTH);
    localparam logic [ROW_W-1:0] SPAN    = ROW_W'(2 * SAND_DEPTH);

    sand_state_e      state_q, state_d;
    logic [6:0]       level_q, level_d;
    logic [ROW_W-1:0] lower_q, lower_d;
    logic [ROW_W-1:0] upper_q, upper_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             tick_en;
    logic             step;

    // A tick only reaches the divider when nothing with higher priority (start, pause) claims the cycle
    assign tick_en = (state_q == ST_RUN) && frame_tick && !pause && !start;

    frame_divider #(
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_frame_divider (
        .clk     (clk),
        .resetn_i(BTN_S),
        .clear_i (start),
        .tick_i  (tick_en),
        .step_o  (step)
    );

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        done_d  = 1'b0;
        if (start) begin
            state_d = ST_RUN;
            level_d = 7'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (step && (level_q < DEPTH_L)) begin
                        level_d = level_q + 7'd1;
                        if (level_q + 7'd1 == DEPTH_L) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
        lower_d   = ori_row - {4'd0, level_d};
        upper_d   = ori_row - SPAN + {4'd0, level_d};
        running_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
    end

    always_ff @(posedge clk) begin
        if (!BTN_S) begin
            state_q   <= ST_IDLE;
            level_q   <= 7'd0;
            lower_q   <= {ROW_W{1'b1}};
            upper_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            lower_q   <= lower_d;
            upper_q   <= upper_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign lower_row = lower_q;
    assign upper_row = upper_q;
    assign running   = running_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sand_level_ctrl.sv
// tb/tb_sand_level_ctrl.sv - self-checking bench for sand_level_ctrl (small and default parameter sets)
module tb_sand_level_ctrl;

    localparam int PH_IDLE   = 0;
    localparam int PH_RUN    = 1;
    localparam int PH_PAUSED = 2;
    localparam int PH_DONE   = 3;

    logic        clk = 1'b0;
    logic        btn_s;
    logic [10:0] ori;
    logic        tick;
    logic        st;
    logic        pa;

    logic [10:0] lo0, up0, lo1, up1;
    logic        run0, dn0, run1, dn1;

    int n_err = 0;
    int n_checks = 0;

    int p_f[2] = '{2, 30};
    int p_d[2] = '{4, 68};
    int m_phase[2], m_level[2], m_ticks[2];
    int m_lower[2], m_upper[2], m_run[2], m_done[2];

    typedef struct {
        bit          rst_n;
        bit          s;
        bit          p;
        bit          t;
        logic [10:0] lo;
        logic [10:0] up;
        bit          run;
        bit          dn;
    } vec_t;

    vec_t tbl[13];

    always #5 clk = ~clk;

    sand_level_ctrl #(.FRAMES_PER_STEP(2), .SAND_DEPTH(4)) u_small (
        .clk(clk), .BTN_S(btn_s), .ori_row(ori), .frame_tick(tick), .start(st), .pause(pa),
        .lower_row(lo0), .upper_row(up0), .running(run0), .done(dn0)
    );

    sand_level_ctrl u_dflt (
        .clk(clk), .BTN_S(btn_s), .ori_row(ori), .frame_tick(tick), .start(st), .pause(pa),
        .lower_row(lo1), .upper_row(up1), .running(run1), .done(dn1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Sand clock behaviour: count ticks while flowing, drop one row of sand every F ticks until full
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 0;
            if (!btn_s) begin
                m_phase[i] = PH_IDLE;
                m_level[i] = 0;
                m_ticks[i] = 0;
            end else if (st) begin
                m_phase[i] = PH_RUN;
                m_level[i] = 0;
                m_ticks[i] = 0;
            end else if (m_phase[i] == PH_RUN) begin
                if (pa) m_phase[i] = PH_PAUSED;
                else if (tick) begin
                    m_ticks[i]++;
                    if (m_ticks[i] == p_f[i]) begin
                        m_ticks[i] = 0;
                        m_level[i]++;
                        if (m_level[i] == p_d[i]) begin
                            m_phase[i] = PH_DONE;
                            m_done[i] = 1;
                        end
                    end
                end
            end else if (m_phase[i] == PH_PAUSED) begin
                if (!pa) m_phase[i] = PH_RUN;
            end
            if (!btn_s) begin
                m_lower[i] = 2047;
                m_upper[i] = 0;
            end else begin
                m_lower[i] = (int'(ori) - m_level[i]) & 2047;
                m_upper[i] = (int'(ori) - 2 * p_d[i] + m_level[i]) & 2047;
            end
            m_run[i] = (m_phase[i] == PH_RUN || m_phase[i] == PH_PAUSED) ? 1 : 0;
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".small.lower"}, lo0, m_lower[0]);
        chk({tag, ".small.upper"}, up0, m_upper[0]);
        chk({tag, ".small.running"}, run0, m_run[0]);
        chk({tag, ".small.done"}, dn0, m_done[0]);
        chk({tag, ".dflt.lower"}, lo1, m_lower[1]);
        chk({tag, ".dflt.upper"}, up1, m_upper[1]);
        chk({tag, ".dflt.running"}, run1, m_run[1]);
        chk({tag, ".dflt.done"}, dn1, m_done[1]);
    endtask

    task automatic cyc(input bit r, input bit s, input bit p, input bit t, input string tag);
        btn_s = r;
        st    = s;
        pa    = p;
        tick  = t;
        @(posedge clk);
        model_step();
        #1;
        compare_model(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount;
        btn_s = 1'b0; st = 1'b0; pa = 1'b0; tick = 1'b0; ori = 11'd400;

        // Full fill of the small instance: one row every 2 ticks, done after 4 rows
        tbl[0]  = '{0, 0, 0, 0, 11'h7FF, 11'd0,   0, 0};
        tbl[1]  = '{1, 0, 0, 0, 11'd400, 11'd392, 0, 0};
        tbl[2]  = '{1, 1, 0, 0, 11'd400, 11'd392, 1, 0};
        tbl[3]  = '{1, 0, 0, 1, 11'd400, 11'd392, 1, 0};
        tbl[4]  = '{1, 0, 0, 1, 11'd399, 11'd393, 1, 0};
        tbl[5]  = '{1, 0, 0, 1, 11'd399, 11'd393, 1, 0};
        tbl[6]  = '{1, 0, 0, 1, 11'd398, 11'd394, 1, 0};
        tbl[7]  = '{1, 0, 0, 1, 11'd398, 11'd394, 1, 0};
        tbl[8]  = '{1, 0, 0, 1, 11'd397, 11'd395, 1, 0};
        tbl[9]  = '{1, 0, 0, 1, 11'd397, 11'd395, 1, 0};
        tbl[10] = '{1, 0, 0, 1, 11'd396, 11'd396, 0, 1};
        tbl[11] = '{1, 0, 0, 0, 11'd396, 11'd396, 0, 0};
        tbl[12] = '{1, 0, 0, 1, 11'd396, 11'd396, 0, 0};

        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].rst_n, tbl[i].s, tbl[i].p, tbl[i].t, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.lower", i), lo0, tbl[i].lo);
            chk($sformatf("tbl%0d.upper", i), up0, tbl[i].up);
            chk($sformatf("tbl%0d.running", i), run0, tbl[i].run);
            chk($sformatf("tbl%0d.done", i), dn0, tbl[i].dn);
        end

        // Start from DONE together with a tick: the tick must not count
        cyc(1, 1, 0, 1, "restart");
        chk("restart.lower", lo0, 400);
        chk("restart.running", run0, 1);
        cyc(1, 0, 0, 1, "restart_t1");
        chk("restart_t1.lower", lo0, 400);
        cyc(1, 0, 0, 1, "restart_t2");
        chk("restart_t2.lower", lo0, 399);

        // Pause across 3 ticks with divider half way, then resume
        cyc(1, 0, 0, 1, "pre_pause");
        chk("pre_pause.lower", lo0, 399);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 1, 1, "paused");
            chk($sformatf("paused%0d.lower", k), lo0, 399);
            chk($sformatf("paused%0d.running", k), run0, 1);
        end
        cyc(1, 0, 0, 0, "unpause");
        cyc(1, 0, 0, 1, "resume");
        chk("resume.lower", lo0, 398);

        // ori_row move at level 2
        ori = 11'd300;
        cyc(1, 0, 0, 0, "ori_move");
        chk("ori_move.lower", lo0, 298);
        chk("ori_move.upper", up0, 294);
        ori = 11'd400;

        // Reset pulse at level 3 overrides start/pause/tick
        cyc(1, 0, 0, 1, "to_l3a");
        cyc(1, 0, 0, 1, "to_l3b");
        chk("level3.lower", lo0, 397);
        cyc(0, 1, 1, 1, "reset_mid");
        chk("reset_mid.lower", lo0, 11'h7FF);
        chk("reset_mid.upper", up0, 0);
        chk("reset_mid.running", run0, 0);
        cyc(1, 0, 0, 0, "post_reset");
        chk("post_reset.lower", lo0, 400);
        chk("post_reset.upper", up0, 392);

        // Default depth with low ori_row: upper row wraps, level saturates at 68
        ori = 11'd50;
        cyc(1, 1, 0, 0, "wrap_start");
        chk("wrap.upper", up1, 1962);
        chk("wrap.lower", lo1, 50);
        dcount = 0;
        for (int k = 0; k < 2040; k++) begin
            cyc(1, 0, 0, 1, "fill");
            if (dn1) dcount++;
        end
        chk("fill.done_pulses", dcount, 1);
        chk("fill.lower", lo1, 2030);
        chk("fill.upper", up1, 2030);
        chk("fill.running", run1, 0);
        for (int k = 0; k < 10; k++) begin
            cyc(1, 0, 0, 1, "overfill");
            if (dn1) dcount++;
        end
        chk("overfill.done_pulses", dcount, 1);
        chk("overfill.lower", lo1, 2030);

        // Random traffic against the reference model
        begin
            bit p_lvl;
            p_lvl = 1'b0;
            for (int k = 0; k < 4000; k++) begin
                if ($urandom_range(0, 9) == 0) p_lvl = ~p_lvl;
                if ($urandom_range(0, 49) == 0) ori = 11'($urandom_range(0, 2047));
                cyc($urandom_range(0, 199) != 0, $urandom_range(0, 299) == 0, p_lvl,
                    $urandom_range(0, 2) != 0, "rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
